add_accum_next: RTL and testbench
=================================

Name: add_accum_next

Overview:
Downstream stage of the 32-bit streaming adder. It consumes the adder's result stream over a valid/ready channel and sums every COUNT consecutive results into one value. Each finished sum is emitted on a registered valid/ready output channel. Used for reduction, such as dot-product tails and block sums, behind the add pipeline stage.

Parameters:
WIDTH, 32, data width of input, accumulator and output (unsigned)
COUNT, 4, number of input beats summed per output beat; legal range 1..2^16
CNT_W, $clog2(COUNT)+1, beat counter width (derived; not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
acc__in0  input  WIDTH  input data (adder result)
acc__in0_vld  input  1  input valid
acc__in0_rdy  output  1  input ready
acc__out0  output  WIDTH  registered group sum
acc__out0_vld  output  1  output valid
acc__out0_rdy  input  1  downstream ready

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high. While rst is high, all state clears immediately: cnt=0, acc=0, out_reg=0, out_vld_reg=0. So acc__out0=0 and acc__out0_vld=0. A partial group in flight at reset is discarded; no output is produced for it.
- Handshakes:
  - Input transfer: acc__in0_vld & acc__in0_rdy at a rising edge.
  - Output transfer: acc__out0_vld & acc__out0_rdy at a rising edge.
- Ready rule:
  - acc__in0_rdy = !(last_beat & out_vld_reg & !acc__out0_rdy), where last_beat = (cnt == COUNT-1).
  - acc__in0_rdy must not depend combinationally on acc__in0_vld.
  - Non-final beats are always accepted. The final beat stalls only while the previous sum is still unconsumed.
- On input transfer:
  - Non-final beat: acc <= (cnt==0 ? acc__in0 : acc + acc__in0); cnt <= cnt+1.
  - Final beat: out_reg <= (cnt==0 ? acc__in0 : acc + acc__in0); out_vld_reg <= 1; cnt <= 0; acc unchanged (it is overwritten by the next beat 0).
- On output transfer with no simultaneous final-beat transfer: out_vld_reg <= 0. A simultaneous output transfer and final-beat transfer loads the new sum with out_vld_reg held at 1, giving full throughput with no bubble.
- Latency: acc__out0_vld rises in the cycle after the final-beat transfer. Steady-state throughput is one input beat per cycle.
- Output stability: acc__out0 is held stable while acc__out0_vld=1 and acc__out0_rdy=0.
- COUNT=1: every beat is a final beat, so the block acts as a one-deep registered pass-through.
- Arithmetic: unsigned, WIDTH bits. The default build wraps modulo 2^WIDTH, and overflow is silently dropped.
- acc__in0 is ignored when acc__in0_vld=0 or no transfer occurs. No X propagates into state.

Optional Feature:
- Macro ADD_ACCUM_SATURATE_EN.
- When defined: every accumulation step saturates. If the true sum exceeds 2^WIDTH-1, the result is 2^WIDTH-1. Once saturated, the group stays saturated because all addends are non-negative.
- When undefined: wrapping add as described above.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package add_pkg: WIDTH default constant, data_t typedef (logic [WIDTH-1:0]), SAT_MAX constant (all ones).
- One natural sub-module: add_sat_unit, a combinational a+b with the saturate path gated by ADD_ACCUM_SATURATE_EN, reusable by the adder stage.
- Counter, ready logic and output register stay in add_accum_next.

Test Plan:
- COUNT=4, inputs 1,2,3,4 on consecutive cycles, acc__out0_rdy=1 -> acc__out0=10 with vld=1 for exactly one cycle, one cycle after beat 4; acc__in0_rdy stays 1 throughout.
- COUNT=4, acc__out0_rdy=0 with sum 10 pending, then feed 5,6,7,8 -> 5,6,7 accepted and acc__in0_rdy=0 on beat 8. Raise acc__out0_rdy -> 10 transfers and 8 is accepted the same edge. Next cycle acc__out0=26 with vld held high and no bubble.
- COUNT=2, inputs 0xFFFFFFFF then 0x00000002 -> default build gives 0x00000001; ADD_ACCUM_SATURATE_EN build gives 0xFFFFFFFF.
- COUNT=4, feed 9,9, then pulse rst mid-cycle (asynchronous) -> acc__out0_vld=0 and acc__out0=0 immediately. Then feed 1,1,1,1 -> acc__out0=4, with no residue from the 9s.
- COUNT=1, inputs 7,8,9 back-to-back with acc__out0_rdy=1 -> outputs 7,8,9 on consecutive cycles, each one cycle after its input.
- Random vld/rdy toggling, COUNT=4, 1000 beats -> every output equals the scoreboard group sum, and acc__out0 never changes while vld=1 and rdy=0.

Source files
------------

// File: rtl/add_pkg.sv
// Shared definitions for the streaming add / accumulate stages.
// Holds the default data width, the data word type and the saturation ceiling.
package add_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

  localparam data_t SAT_MAX = '1;

endpackage : add_pkg

// File: rtl/add_sat_unit.sv
// Combinational unsigned adder: sum = a + b.
// Default build wraps modulo 2^WIDTH. With ADD_ACCUM_SATURATE_EN defined,
// any result above 2^WIDTH-1 clamps to all ones.
module add_sat_unit
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

`ifdef ADD_ACCUM_SATURATE_EN
  logic [WIDTH:0] full;

  // Widen by one bit so the carry-out flags an overflow to clamp on
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sum  = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
  end
`else
  // Plain wrapping add; any carry-out is discarded
  always_comb begin
    sum = a + b;
  end
`endif

endmodule : add_sat_unit

// File: rtl/add_accum_next.sv
// Group accumulator: sums every COUNT accepted input beats and emits the
// sum on a registered valid/ready output. Only the final beat of a group
// can stall, and only while the previous sum is still unconsumed.
// Optional macro ADD_ACCUM_SATURATE_EN switches the adder to saturating.
module add_accum_next
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] acc__in0,
  input  logic             acc__in0_vld,
  output logic             acc__in0_rdy,
  output logic [WIDTH-1:0] acc__out0,
  output logic             acc__out0_vld,
  input  logic             acc__out0_rdy
);

  localparam int CNT_W = $clog2(COUNT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] out_reg;
  logic             out_vld_reg;

  logic             last_beat;
  logic             first_beat;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] step_sum;

  // Handshake decode; ready deliberately ignores acc__in0_vld
  always_comb begin
    last_beat    = (cnt == LAST_CNT);
    first_beat   = (cnt == '0);
    acc__in0_rdy = !(last_beat && out_vld_reg && !acc__out0_rdy);
    in_xfer      = acc__in0_vld && acc__in0_rdy;
    out_xfer     = out_vld_reg && acc__out0_rdy;
    addend       = first_beat ? '0 : acc;
  end

  add_sat_unit #(
    .WIDTH(WIDTH)
  ) u_add (
    .a  (addend),
    .b  (acc__in0),
    .sum(step_sum)
  );

  // Beat counter, running sum and output register with a no-bubble reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      out_reg     <= '0;
      out_vld_reg <= 1'b0;
    end else begin
      if (in_xfer) begin
        if (last_beat) begin
          out_reg <= step_sum;
          cnt     <= '0;
        end else begin
          acc <= step_sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (in_xfer && last_beat) begin
        out_vld_reg <= 1'b1;
      end else if (out_xfer) begin
        out_vld_reg <= 1'b0;
      end
    end
  end

  assign acc__out0     = out_reg;
  assign acc__out0_vld = out_vld_reg;

endmodule : add_accum_next

// File: tb/tb_add_accum_next.sv
// Self-checking bench for add_accum_next: three instances (COUNT=4, 2, 1),
// a group-sum model with a per-cycle compare process on the COUNT=4
// instance, and directed literal expectations for every instance.
module tb_add_accum_next;

  logic        clk;
  logic        rst;

  logic [31:0] in4, out4;
  logic        in_vld4, in_rdy4, out_vld4, out_rdy4;
  logic [31:0] in2, out2;
  logic        in_vld2, in_rdy2, out_vld2, out_rdy2;
  logic [31:0] in1, out1;
  logic        in_vld1, in_rdy1, out_vld1, out_rdy1;

  int total;
  int bad;

  add_accum_next #(.WIDTH(32), .COUNT(4)) dut4 (
    .clk(clk), .rst(rst),
    .acc__in0(in4), .acc__in0_vld(in_vld4), .acc__in0_rdy(in_rdy4),
    .acc__out0(out4), .acc__out0_vld(out_vld4), .acc__out0_rdy(out_rdy4)
  );

  add_accum_next #(.WIDTH(32), .COUNT(2)) dut2 (
    .clk(clk), .rst(rst),
    .acc__in0(in2), .acc__in0_vld(in_vld2), .acc__in0_rdy(in_rdy2),
    .acc__out0(out2), .acc__out0_vld(out_vld2), .acc__out0_rdy(out_rdy2)
  );

  add_accum_next #(.WIDTH(32), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst),
    .acc__in0(in1), .acc__in0_vld(in_vld1), .acc__in0_rdy(in_rdy1),
    .acc__out0(out1), .acc__out0_vld(out_vld1), .acc__out0_rdy(out_rdy1)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Group result as defined arithmetically: true sum, then wrap or clamp
  function automatic logic [31:0] groupResult(input longint unsigned s);
`ifdef ADD_ACCUM_SATURATE_EN
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
    return s[31:0];
`endif
  endfunction

  // Model state for the COUNT=4 instance
  longint unsigned grp_sum;
  int              grp_n;
  logic [31:0]     exp_q[$];
  logic            prev_hold;
  logic [31:0]     prev_out;

  // Per-cycle compare against the group-sum model, then advance the model
  always @(negedge clk or posedge rst) begin
    logic exp_rdy;
    if (rst) begin
      grp_sum   = 0;
      grp_n     = 0;
      exp_q.delete();
      prev_hold = 1'b0;
      prev_out  = '0;
    end else begin
      exp_rdy = !(grp_n == 3 && exp_q.size() > 0 && !out_rdy4);
      checkOutput("model_in_rdy", {31'b0, in_rdy4}, {31'b0, exp_rdy});
      checkOutput("model_out_vld", {31'b0, out_vld4}, {31'b0, exp_q.size() > 0});
      if (exp_q.size() > 0) checkOutput("model_out_data", out4, exp_q[0]);
      if (prev_hold) checkOutput("hold_stable", out4, prev_out);
      prev_hold = out_vld4 && !out_rdy4;
      prev_out  = out4;
      if (exp_q.size() > 0 && out_rdy4) void'(exp_q.pop_front());
      if (in_vld4 && exp_rdy) begin
        grp_sum += longint'(in4);
        grp_n++;
        if (grp_n == 4) begin
          exp_q.push_back(groupResult(grp_sum));
          grp_sum = 0;
          grp_n   = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic ordy);
    in_vld4  = vld;
    in4      = data;
    out_rdy4 = ordy;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in4 = '0; in_vld4 = 1'b0; out_rdy4 = 1'b1;
    in2 = '0; in_vld2 = 1'b0; out_rdy2 = 1'b1;
    in1 = '0; in_vld1 = 1'b0; out_rdy1 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    checkOutput("reset_vld", {31'b0, out_vld4}, 32'd0);
    checkOutput("reset_data", out4, 32'd0);
    checkOutput("reset_rdy", {31'b0, in_rdy4}, 32'd1);

    // 1,2,3,4 with downstream ready -> 10 for exactly one cycle
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1);
      tick();
      checkOutput("t1_rdy", {31'b0, in_rdy4}, 32'd1);
    end
    checkOutput("t1_vld", {31'b0, out_vld4}, 32'd1);
    checkOutput("t1_sum", out4, 32'd10);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    checkOutput("t1_vld_drop", {31'b0, out_vld4}, 32'd0);

    // Backpressure: 10 pending, 5,6,7 accepted, 8 stalls until the drain
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      tick();
    end
    checkOutput("t2_pend_vld", {31'b0, out_vld4}, 32'd1);
    checkOutput("t2_pend_sum", out4, 32'd10);
    for (int i = 5; i <= 7; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      tick();
    end
    checkOutput("t2_stall_rdy", {31'b0, in_rdy4}, 32'd0);
    applyStimulus(1'b1, 32'd8, 1'b0);
    tick();
    checkOutput("t2_stall_rdy2", {31'b0, in_rdy4}, 32'd0);
    checkOutput("t2_hold_sum", out4, 32'd10);
    applyStimulus(1'b1, 32'd8, 1'b1);
    #1;
    checkOutput("t2_release_rdy", {31'b0, in_rdy4}, 32'd1);
    tick();
    checkOutput("t2_nobubble_vld", {31'b0, out_vld4}, 32'd1);
    checkOutput("t2_sum26", out4, 32'd26);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    checkOutput("t2_drain_vld", {31'b0, out_vld4}, 32'd0);

    // Asynchronous reset discards a pending sum and a partial group
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'd1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'd9, 1'b0);
    tick();
    applyStimulus(1'b1, 32'd9, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("t4_pre_vld", {31'b0, out_vld4}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t4_async_vld", {31'b0, out_vld4}, 32'd0);
    checkOutput("t4_async_data", out4, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'd1, 1'b1);
      tick();
    end
    checkOutput("t4_clean_vld", {31'b0, out_vld4}, 32'd1);
    checkOutput("t4_clean_sum", out4, 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();

    // COUNT=2 overflow: wraps to 1, or clamps when saturating
    in_vld2 = 1'b1; in2 = 32'hFFFF_FFFF;
    tick();
    in2 = 32'h0000_0002;
    tick();
    in_vld2 = 1'b0;
    checkOutput("t3_vld", {31'b0, out_vld2}, 32'd1);
`ifdef ADD_ACCUM_SATURATE_EN
    checkOutput("t3_sat", out2, 32'hFFFF_FFFF);
`else
    checkOutput("t3_wrap", out2, 32'h0000_0001);
`endif
    tick();
    checkOutput("t3_vld_drop", {31'b0, out_vld2}, 32'd0);

    // COUNT=1 pass-through: each value appears one cycle after it is sent
    for (int i = 7; i <= 9; i++) begin
      in_vld1 = 1'b1; in1 = 32'(i);
      tick();
      checkOutput("t5_vld", {31'b0, out_vld1}, 32'd1);
      checkOutput("t5_data", out1, 32'(i));
      checkOutput("t5_rdy", {31'b0, in_rdy1}, 32'd1);
    end
    in_vld1 = 1'b0;
    tick();
    checkOutput("t5_vld_drop", {31'b0, out_vld1}, 32'd0);

    // Random valid/ready toggling on COUNT=4, checked by the model
    for (int c = 0; c < 2500; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b1);
    repeat (4) tick();
    checkOutput("final_drain", {31'b0, out_vld4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_add_accum_next
